// File: rtl/nco_sweep_ctrl_pkg.sv
// nco_pkg: shared widths, sweep mode codes and FSM state encoding
// for the NCO sweep controller and its step calculator.
package nco_pkg;

   localparam int ACC_SIZE = 8;
   localparam int STEP_W   = ACC_SIZE + 1;

   localparam logic [1:0] MODE_SINGLE   = 2'b00;
   localparam logic [1:0] MODE_REPEAT   = 2'b01;
   localparam logic [1:0] MODE_PINGPONG = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      DWELL,
      DONE
   } state_e;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// nco_sweep_ctrl_if: host/NCO side bundle of the sweep controller.
// Inputs: start, abort, cfg_*. Outputs: step, nco_reset, step_strobe, busy, done.
interface nco_sweep_ctrl_if #(
   parameter int STEP_W  = nco_pkg::STEP_W,
   parameter int DWELL_W = 16
);

   logic                      start;
   logic                      abort;
   logic signed [STEP_W-1:0]  cfg_start;
   logic signed [STEP_W-1:0]  cfg_stop;
   logic signed [STEP_W-1:0]  cfg_delta;
   logic        [DWELL_W-1:0] cfg_dwell;
   logic        [1:0]         cfg_mode;
   logic signed [STEP_W-1:0]  step;
   logic                      nco_reset;
   logic                      step_strobe;
   logic                      busy;
   logic                      done;

   modport master (
      output start, abort,
      output cfg_start, cfg_stop, cfg_delta,
      output cfg_dwell, cfg_mode,
      input  step, nco_reset, step_strobe,
      input  busy, done
   );

   modport slave (
      input  start, abort,
      input  cfg_start, cfg_stop, cfg_delta,
      input  cfg_dwell, cfg_mode,
      output step, nco_reset, step_strobe,
      output busy, done
   );

endinterface

// File: rtl/nco_sweep_ctrl_step_calc.sv
// nco_step_calc: combinational clamped advance of a signed step toward target.
// In: step, delta, target. Out: next_step (clamped), leg_end (no further progress).
module nco_step_calc #(
   parameter int STEP_W = nco_pkg::STEP_W
) (
   input  logic signed [STEP_W-1:0] step,
   input  logic signed [STEP_W-1:0] delta,
   input  logic signed [STEP_W-1:0] target,
   output logic signed [STEP_W-1:0] next_step,
   output logic                     leg_end
);

   logic signed [STEP_W:0] sum;
   logic signed [STEP_W:0] tgt_x;
   logic                   pos;
   logic                   neg;

   // one extra bit so the sum can never wrap before the clamp compare
   assign sum   = $signed({step[STEP_W-1], step})
                + $signed({delta[STEP_W-1], delta});
   assign tgt_x = $signed({target[STEP_W-1], target});
   assign neg   = delta[STEP_W-1];
   assign pos   = !neg && (delta != '0);

   always_comb begin
      next_step = sum[STEP_W-1:0];
      leg_end   = 1'b0;
      unique case (1'b1)
         pos: begin
            if (sum >= tgt_x) next_step = target;
            leg_end = (step >= target);
         end
         neg: begin
            if (sum <= tgt_x) next_step = target;
            leg_end = (step <= target);
         end
         default: begin
            next_step = step;
            leg_end   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: latches a sweep config on start and steps the NCO through it.
// Ports: clk, reset (async active-low), bus (slave: start/abort/cfg_* in, step/status out).
module nco_sweep_ctrl #(
   parameter int ACC_SIZE = nco_pkg::ACC_SIZE,
   parameter int STEP_W   = ACC_SIZE + 1,
   parameter int DWELL_W  = 16
) (
   input logic              clk,
   input logic              reset,
   nco_sweep_ctrl_if.slave  bus
);

   import nco_pkg::*;

   localparam logic signed [STEP_W-1:0] SMIN =
      {1'b1, {(STEP_W-1){1'b0}}};

   state_e                    state;
   logic signed [STEP_W-1:0]  start_r;
   logic signed [STEP_W-1:0]  stop_r;
   logic signed [STEP_W-1:0]  delta_r;
   logic        [DWELL_W-1:0] dwell_m1;
   logic        [1:0]         mode_r;
   logic                      fwd_leg;
   logic        [DWELL_W-1:0] cnt;

   logic signed [STEP_W-1:0]  step_r;
   logic                      nco_reset_r;
   logic                      strobe_r;
   logic                      busy_r;
   logic                      done_r;

   logic signed [STEP_W-1:0]  tgt;
   logic signed [STEP_W-1:0]  rev_tgt;
   logic signed [STEP_W-1:0]  neg_delta;
   logic signed [STEP_W-1:0]  fwd_nxt;
   logic signed [STEP_W-1:0]  rev_nxt;
   logic                      fwd_end;
   logic                      rev_end;

   assign tgt       = fwd_leg ? stop_r  : start_r;
   assign rev_tgt   = fwd_leg ? start_r : stop_r;
   assign neg_delta = -delta_r;

   nco_step_calc #(.STEP_W(STEP_W)) u_fwd (
      .step      (step_r),
      .delta     (delta_r),
      .target    (tgt),
      .next_step (fwd_nxt),
      .leg_end   (fwd_end)
   );

   // ping-pong turnaround: advance from the endpoint along the reversed leg
   nco_step_calc #(.STEP_W(STEP_W)) u_rev (
      .step      (step_r),
      .delta     (neg_delta),
      .target    (rev_tgt),
      .next_step (rev_nxt),
      .leg_end   (rev_end)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         start_r     <= '0;
         stop_r      <= '0;
         delta_r     <= '0;
         dwell_m1    <= '0;
         mode_r      <= MODE_SINGLE;
         fwd_leg     <= 1'b1;
         cnt         <= '0;
         step_r      <= '0;
         nco_reset_r <= 1'b0;
         strobe_r    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         nco_reset_r <= 1'b0;
         strobe_r    <= 1'b0;
         done_r      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  start_r  <= bus.cfg_start;
                  stop_r   <= bus.cfg_stop;
                  // keep delta negatable
                  delta_r  <= (bus.cfg_delta == SMIN) ?
                              SMIN + STEP_W'(1) : bus.cfg_delta;
                  dwell_m1 <= (bus.cfg_dwell == '0) ?
                              '0 : bus.cfg_dwell - DWELL_W'(1);
                  cnt      <= (bus.cfg_dwell == '0) ?
                              '0 : bus.cfg_dwell - DWELL_W'(1);
                  mode_r   <= (bus.cfg_mode == 2'b11) ?
                              MODE_SINGLE : bus.cfg_mode;
                  fwd_leg     <= 1'b1;
                  step_r      <= bus.cfg_start;
                  nco_reset_r <= 1'b1;
                  strobe_r    <= 1'b1;
                  busy_r      <= 1'b1;
                  state       <= PRIME;
               end
            end
            PRIME, DWELL: begin
               if (bus.abort) begin
                  state  <= IDLE;
                  step_r <= '0;
                  busy_r <= 1'b0;
                  cnt    <= '0;
               end else if (cnt != '0) begin
                  cnt   <= cnt - DWELL_W'(1);
                  state <= DWELL;
               end else if (!fwd_end) begin
                  step_r   <= fwd_nxt;
                  strobe_r <= 1'b1;
                  cnt      <= dwell_m1;
                  state    <= DWELL;
               end else begin
                  unique case (mode_r)
                     MODE_REPEAT: begin
                        step_r   <= start_r;
                        strobe_r <= 1'b1;
                        cnt      <= dwell_m1;
                        state    <= DWELL;
                     end
                     MODE_PINGPONG: begin
                        delta_r  <= neg_delta;
                        fwd_leg  <= !fwd_leg;
                        // both endpoints coincide: hold
                        step_r   <= rev_end ? step_r : rev_nxt;
                        strobe_r <= 1'b1;
                        cnt      <= dwell_m1;
                        state    <= DWELL;
                     end
                     default: begin
                        step_r <= '0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        cnt    <= '0;
                        state  <= DONE;
                     end
                  endcase
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.step        = step_r;
   assign bus.nco_reset   = nco_reset_r;
   assign bus.step_strobe = strobe_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: directed self-checking bench for nco_sweep_ctrl
// (STEP_W=9): reset, single, clamp, ping-pong, repeat, degenerate configs.
module tb_nco_sweep_ctrl;

   import nco_pkg::*;

   logic clk;
   logic reset;
   int   n_asrt;
   int   n_fail;

   nco_sweep_ctrl_if #(.STEP_W(9), .DWELL_W(16)) bus ();

   nco_sweep_ctrl #(.ACC_SIZE(8), .DWELL_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic st(input string tag, input int s, input int sb,
                     input int nr, input int b, input int d);
      chk({tag, ".step"}, int'(bus.step), s);
      chk({tag, ".strobe"}, int'(bus.step_strobe), sb);
      chk({tag, ".nco_reset"}, int'(bus.nco_reset), nr);
      chk({tag, ".busy"}, int'(bus.busy), b);
      chk({tag, ".done"}, int'(bus.done), d);
   endtask

   task automatic cfg(input int s, input int p, input int d,
                      input int w, input logic [1:0] m);
      bus.cfg_start = 9'(s);
      bus.cfg_stop  = 9'(p);
      bus.cfg_delta = 9'(d);
      bus.cfg_dwell = 16'(w);
      bus.cfg_mode  = m;
   endtask

   task automatic go();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   int seq_up [4]  = '{1, 3, 5, 7};
   int seq_cl [4]  = '{0, 2, 4, 5};
   int seq_pp [7]  = '{-2, 0, 2, 0, -2, 0, 2};
   int seq_rp [6]  = '{3, 0, -3, 3, 0, -3};
   int seq_mn [4]  = '{255, 0, -255, -256};

   initial begin
      n_asrt = 0;
      n_fail = 0;
      reset = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      cfg(0, 0, 0, 0, MODE_SINGLE);
      #3;
      st("rst", 0, 0, 0, 0, 0);
      tick();
      reset = 1'b1;
      tick();
      st("idle", 0, 0, 0, 0, 0);

      // reset asserted mid-sweep clears outputs immediately
      cfg(1, 7, 2, 3, MODE_REPEAT);
      go();
      st("rst_pre", 1, 1, 1, 1, 0);
      reset = 1'b0;
      #1;
      st("rst_mid", 0, 0, 0, 0, 0);
      #2;
      reset = 1'b1;
      tick();
      st("rst_post", 0, 0, 0, 0, 0);

      // single up sweep
      cfg(1, 7, 2, 3, MODE_SINGLE);
      go();
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 3; c++) begin
            st($sformatf("up%0d_%0d", i, c), seq_up[i],
               (c == 0) ? 1 : 0, (i == 0 && c == 0) ? 1 : 0, 1, 0);
            tick();
         end
      end
      st("up_done", 0, 0, 0, 0, 1);
      tick();
      st("up_idle", 0, 0, 0, 0, 0);

      // clamp at stop, start while busy ignored
      cfg(0, 5, 2, 1, MODE_SINGLE);
      go();
      for (int i = 0; i < 4; i++) begin
         st($sformatf("cl%0d", i), seq_cl[i], 1, (i == 0) ? 1 : 0, 1, 0);
         if (i == 1) begin
            bus.start = 1'b1;
            cfg(100, -50, -7, 9, MODE_REPEAT);
         end
         tick();
         bus.start = 1'b0;
      end
      st("cl_done", 0, 0, 0, 0, 1);
      tick();
      st("cl_idle", 0, 0, 0, 0, 0);

      // ping-pong then abort
      cfg(-2, 2, 2, 1, MODE_PINGPONG);
      go();
      for (int i = 0; i < 7; i++) begin
         st($sformatf("pp%0d", i), seq_pp[i], 1, (i == 0) ? 1 : 0, 1, 0);
         tick();
      end
      st("pp7", 0, 1, 0, 1, 0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      st("pp_abort", 0, 0, 0, 0, 0);
      tick();
      st("pp_after", 0, 0, 0, 0, 0);

      // repeat, downward
      cfg(3, -3, -3, 2, MODE_REPEAT);
      go();
      for (int i = 0; i < 6; i++) begin
         for (int c = 0; c < 2; c++) begin
            st($sformatf("rp%0d_%0d", i, c), seq_rp[i],
               (c == 0) ? 1 : 0, (i == 0 && c == 0) ? 1 : 0, 1, 0);
            tick();
         end
      end
      st("rp_wrap", 3, 1, 0, 1, 0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      st("rp_abort", 0, 0, 0, 0, 0);

      // start and abort together in IDLE
      cfg(3, -3, -3, 2, MODE_REPEAT);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      st("sa0", 0, 0, 0, 0, 0);
      tick();
      st("sa1", 0, 0, 0, 0, 0);

      // dwell=0, delta=0
      cfg(4, 0, 0, 0, 2'b11);
      go();
      st("dg0", 4, 1, 1, 1, 0);
      tick();
      st("dg_done", 0, 0, 0, 0, 1);
      tick();

      // most-negative delta latched as -255
      cfg(255, -256, -256, 1, MODE_SINGLE);
      go();
      for (int i = 0; i < 4; i++) begin
         st($sformatf("mn%0d", i), seq_mn[i], 1, (i == 0) ? 1 : 0, 1, 0);
         tick();
      end
      st("mn_done", 0, 0, 0, 0, 1);
      tick();
      st("mn_idle", 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep scheduler for the NCO. Latches a sweep configuration on a start pulse and drives the NCO `step` input through a programmed sequence of phase increments, holding each value for a programmable dwell. Supports single, repeating and ping-pong sweeps. It also emits a one-cycle phase-reset pulse to the NCO at sweep start, and exposes busy/done status to the host sequencer.

## Interface
- `ACC_SIZE`, 8: NCO phase accumulator width (6 integer + 2 fractional).
- `STEP_W`, `ACC_SIZE+1`: signed step width, matching NCO `step`.
- `DWELL_W`, 16: dwell counter width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: sweep request pulse; sampled only in IDLE.
- `abort` in 1: terminate sweep.
- `cfg_start` in STEP_W signed: first step value.
- `cfg_stop` in STEP_W signed: end-point step value.
- `cfg_delta` in STEP_W signed: increment per advance; sign gives direction.
- `cfg_dwell` in DWELL_W: cycles each step value is held; 0 is treated as 1.
- `cfg_mode` in 2: 00 single, 01 repeat, 10 ping-pong, 11 treated as single.
- `step` out STEP_W signed: to NCO `step`.
- `nco_reset` out 1: active-high one-cycle pulse to the NCO reset.
- `step_strobe` out 1: one-cycle pulse whenever `step` takes a new value, including a repeated value.
- `busy` out 1: high in PRIME and DWELL.
- `done` out 1: one-cycle pulse at normal completion.

## Operation
- States:
  - IDLE:
    - `start=1` and `abort=0`: go to PRIME.
    - `start` and `abort` together: abort wins; remain in IDLE.
  - PRIME: go to DWELL, or advance directly if dwell=1.
  - DWELL: hold until the dwell counter reaches 0, then advance or end the leg.
  - DONE: one cycle only, then IDLE.
- Config is latched on start acceptance. `cfg_*` changes while busy have no effect. `start` while busy is ignored.
- `cfg_delta` equal to the most negative value is latched as most-negative+1, so negation is always legal.
- Advance rule:
  - `next = step + delta`, computed at STEP_W+1 bits.
  - delta>0 with `next >= target`, or delta<0 with `next <= target`: `step <= target`.
  - Otherwise `step <= next`.
  - Clamping to target means `step` never overflows.
- Leg end: current `step == target`, or `delta == 0`, or start already lies beyond target in the delta direction. The current value completes its dwell first.
- On leg end:
  - Single: go to DONE. `step <= 0`, `done=1`.
  - Repeat: `step <= cfg_start`, `step_strobe=1`, no `nco_reset`.
  - Ping-pong: negate delta, swap target between start and stop, then apply the advance rule from the current step. The endpoint is not repeated.
- Abort in PRIME/DWELL: next cycle IDLE, `step=0`, `busy=0`, no `done`.
- Reset values: state IDLE, `step=0`, `nco_reset=0`, `step_strobe=0`, `busy=0`, `done=0`, dwell counter 0. An asynchronous reset mid-sweep discards all latched config.

## Timing
- `start` accepted at edge t. In cycle t+1 (PRIME): `step=cfg_start`, `nco_reset=1`, `step_strobe=1`, `busy=1`.
- Each step value is presented for exactly max(`cfg_dwell`,1) cycles. PRIME counts as the first cycle of the first dwell.
- Advance is registered. The new `step` appears in the cycle after the dwell counter reaches 0, with `step_strobe` high in that cycle.
- For single mode with N step values and dwell D: `done` occurs in cycle t+1+N·D, with `busy=0` and `step=0` in that cycle.
- `abort` sampled at edge a: `busy=0` and `step=0` from cycle a+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `nco_pkg` holds:
  - `ACC_SIZE`, `STEP_W`.
  - Mode constants `MODE_SINGLE`, `MODE_REPEAT`, `MODE_PINGPONG`.
  - State encoding IDLE/PRIME/DWELL/DONE.
- Sub-module `nco_step_calc` is combinational. It takes step, delta and target, and produces the clamped next step and a leg-end flag. It is reused by future chirp generators.
- The top level holds the FSM, dwell counter, config registers and output registers.

## Test plan
All scenarios use STEP_W=9.
1. Reset:
   - Assert `reset=0` mid-sweep: all outputs 0 immediately.
   - After release, `start` works normally.
2. Single up sweep:
   - start=1, stop=7, delta=2, dwell=3, mode 00.
   - `step` = 1,3,5,7, each for 3 cycles from t+1; `nco_reset` only at t+1.
   - `done` at t+13, then `step=0`.
3. Clamp:
   - start=0, stop=5, delta=2, dwell=1, single.
   - `step` = 0,2,4,5, then `done`.
   - `start` pulsed while busy is ignored.
4. Ping-pong:
   - start=-2, stop=2, delta=2, dwell=1.
   - `step` = -2,0,2,0,-2,0,2…, with `step_strobe` every cycle.
   - Abort: `step=0` and `busy=0` next cycle, no `done`.
5. Repeat, downward:
   - start=3, stop=-3, delta=-3, dwell=2.
   - `step` = 3,0,-3,3,0,-3…; `nco_reset` only once.
   - Simultaneous `start`+`abort` in IDLE: no sweep.
6. Degenerate configs:
   - dwell=0, delta=0, start=4, single: `step=4` for 1 cycle, then `done`.
   - delta=-256: latched as -255 and behaves as such.
